// File: rtl/data_c_pipe_collect.sv
// ---------------------------------------------------------------------------
// data_c_pipe_collect
//   Packs NUM consecutive DSIZE-bit beats from an upstream valid/ready seam
//   into one NUM*DSIZE-bit word. A word closes when NUM beats have been
//   collected or when a beat arrives with in_last set; lanes not filled by an
//   early-closed word read as zero. The output register holds a word until the
//   downstream accepts it. A closing beat may load a new word in the same cycle
//   the previous word is taken, so a full-rate stream is sustained.
//
// Parameters
//   NUM       beats per output word (>= 1)
//   DSIZE     width of one beat
//   MSB_FIRST 0: beat k -> lane k, 1: beat k -> lane NUM-1-k
//
// Ports
//   clock     rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  upstream beat valid
//   in_data   upstream beat data
//   in_last   closes the current word early (qualified by in_valid)
//   in_ready  beat accepted this cycle (combinational)
//   out_valid packed word valid
//   out_data  packed word, lane j = out_data[j*DSIZE +: DSIZE]
//   out_cnt   number of filled lanes (1..NUM)
//   out_last  word was closed by in_last
//   out_ready downstream accepts the word
// ---------------------------------------------------------------------------
module data_c_pipe_collect #(
  parameter int unsigned NUM       = 4,
  parameter int unsigned DSIZE     = 32,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DSIZE-1:0]         in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [NUM*DSIZE-1:0]     out_data,
  output logic [$clog2(NUM+1)-1:0] out_cnt,
  output logic                     out_last,
  input  logic                     out_ready
);

  // Fill counter needs at least one bit even when NUM == 1.
  localparam int unsigned CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned OCW = $clog2(NUM + 1);

  // Accumulate register
  logic [NUM*DSIZE-1:0] r_lanes;
  logic [CW-1:0]        r_cnt;

  // Output register
  logic                 r_out_valid;
  logic [NUM*DSIZE-1:0] r_out_data;
  logic [OCW-1:0]       r_out_cnt;
  logic                 r_out_last;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_full;
  logic                 w_close;
  logic [CW-1:0]        w_lane;
  logic [NUM*DSIZE-1:0] w_merged;
  logic [OCW-1:0]       w_cnt_inc;

  // Ready only depends on the output register, so a pending word that is
  // being taken this cycle frees room for a new closing beat.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_full     = (r_cnt == CW'(NUM - 1));
  assign w_close    = w_accept && (in_last || w_full);
  assign w_cnt_inc  = OCW'(r_cnt) + OCW'(1);

  always_comb begin
    w_lane = r_cnt;
    if (MSB_FIRST) begin
      w_lane = CW'(NUM - 1) - r_cnt;
    end
  end

  // Accumulated lanes with the current beat dropped into its lane.
  always_comb begin
    w_merged = r_lanes;
    for (int unsigned j = 0; j < NUM; j++) begin
      if (CW'(j) == w_lane) begin
        w_merged[j*DSIZE +: DSIZE] = in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_lanes     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_close) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_merged;
        r_out_cnt   <= w_cnt_inc;
        r_out_last  <= in_last;
        r_lanes     <= '0;
        r_cnt       <= '0;
      end else begin
        if (w_accept) begin
          r_lanes <= w_merged;
          r_cnt   <= r_cnt + CW'(1);
        end
        // Word taken with nothing new to replace it; data keeps its value.
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_last  = r_out_last;

endmodule
